cdb_arbiter: RTL and testbench

//  Arbitrates functional-unit (FU) writeback onto the common data bus (CDB) of the OoO core.
//  NUM_REQ FUs (ALU, MUL, LSU, BRU) compete for NUM_CDB broadcast slots per cycle.

---
 rtl/cdb_arbiter.sv | 155 +++++++++++++++
 tb/tb_cdb_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbitration of FU writebacks onto NUM_CDB common-data-bus slots.
// Latency: 1 cycle. A grant in cycle N is broadcast on cdb_* in cycle N+1.
// Backpressure: FUs hold a request until req_ready; the CDB stage has no backpressure.
// Optional feature macro: CDB_AGE_PRIO_EN (starvation age counters, promote at STARVE_LIM).
// Ports:
//   clk, rst        core clock, synchronous active-high reset
//   flush           pipeline squash: no grants this cycle, no broadcast next cycle
//   req_valid/tag/data  per-FU result request, packed slice i per FU
//   req_ready       per-FU grant (combinational from valid, rr_ptr, flush, ages)
//   cdb_valid/tag/data/src  registered per-slot broadcast; unused slots are all-zero
module cdb_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int NUM_CDB    = 2,
  parameter int TAG_W      = 6,
  parameter int DATA_W     = 32,
  parameter int STARVE_LIM = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_CDB-1:0]        cdb_valid,
  output logic [NUM_CDB*TAG_W-1:0]  cdb_tag,
  output logic [NUM_CDB*DATA_W-1:0] cdb_data,
  output logic [NUM_CDB*3-1:0]      cdb_src
);

  localparam int PW = $clog2(NUM_REQ);

  // Reject illegal configurations at elaboration time.
  if (NUM_REQ < 2 || NUM_REQ > 8 || NUM_CDB < 1 || NUM_CDB > NUM_REQ || STARVE_LIM < 1)
  begin : g_bad_param
    $error("cdb_arbiter: illegal parameter combination");
  end

  // Increment a requester index modulo NUM_REQ (NUM_REQ need not be a power of two).
  function automatic logic [PW-1:0] nxt_idx(input logic [PW-1:0] p);
    return (p == PW'(NUM_REQ - 1)) ? '0 : p + PW'(1);
  endfunction

  logic [PW-1:0]        rr_ptr;
  logic [NUM_REQ-1:0]   starved;
  logic [NUM_REQ-1:0]   grant;
  int                   rank [NUM_REQ];
  logic [PW-1:0]        last;
  logic [PW-1:0]        idx;
  int                   gcnt;
  logic                 en;

  logic [NUM_CDB-1:0]        nxt_valid;
  logic [NUM_CDB*TAG_W-1:0]  nxt_tag;
  logic [NUM_CDB*DATA_W-1:0] nxt_data;
  logic [NUM_CDB*3-1:0]      nxt_src;

  // Grant selection. Starved requesters are collected first in round-robin order,
  // then the normal round-robin scan fills whatever slots remain. rank records the
  // order of grants, which is also the slot each grant lands in.
  always_comb begin
    grant = '0;
    gcnt  = 0;
    last  = rr_ptr;
    en    = !rst && !flush;
    for (int i = 0; i < NUM_REQ; i++) rank[i] = 0;

    idx = rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (en && req_valid[idx] && starved[idx] && gcnt < NUM_CDB) begin
        grant[idx] = 1'b1;
        rank[idx]  = gcnt;
        gcnt       = gcnt + 1;
      end
      idx = nxt_idx(idx);
    end

    idx = rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (en && req_valid[idx] && !grant[idx] && gcnt < NUM_CDB) begin
        grant[idx] = 1'b1;
        rank[idx]  = gcnt;
        gcnt       = gcnt + 1;
      end
      idx = nxt_idx(idx);
    end

    // The pointer advances past the granted requester furthest along the scan,
    // so a promoted requester beyond the normal winners still moves the pointer.
    idx = rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant[idx]) last = idx;
      idx = nxt_idx(idx);
    end
  end

  assign req_ready = grant;

  // Route the j-th grant onto slot j; empty slots stay all-zero.
  always_comb begin
    nxt_valid = '0;
    nxt_tag   = '0;
    nxt_data  = '0;
    nxt_src   = '0;
    for (int j = 0; j < NUM_CDB; j++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i] && rank[i] == j) begin
          nxt_valid[j]                 = 1'b1;
          nxt_tag[j*TAG_W +: TAG_W]    = req_tag[i*TAG_W +: TAG_W];
          nxt_data[j*DATA_W +: DATA_W] = req_data[i*DATA_W +: DATA_W];
          nxt_src[j*3 +: 3]            = 3'(i);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      cdb_valid <= '0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      cdb_src   <= '0;
    end else begin
      cdb_valid <= nxt_valid;
      cdb_tag   <= nxt_tag;
      cdb_data  <= nxt_data;
      cdb_src   <= nxt_src;
      if (|grant) rr_ptr <= nxt_idx(last);
    end
  end

`ifdef CDB_AGE_PRIO_EN
  localparam int AW = $clog2(STARVE_LIM + 1);
  logic [AW-1:0] age [NUM_REQ];

  // Counts consecutive cycles a requester waited; saturates at STARVE_LIM.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rst || flush || !req_valid[i] || grant[i])
        age[i] <= '0;
      else if (age[i] != AW'(STARVE_LIM))
        age[i] <= age[i] + AW'(1);
    end
  end

  always_comb begin
    starved = '0;
    for (int i = 0; i < NUM_REQ; i++) starved[i] = (age[i] == AW'(STARVE_LIM));
  end
`else
  assign starved = '0;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed checks of cdb_arbiter with two slots (dut) and one slot (dut1).
// Inputs change 1 time unit after posedge; outputs are sampled away from the edge.
// dut1 uses STARVE_LIM=2 so the age-priority scenario can run when the feature is built.
module tb_cdb_arbiter;
  localparam int NR = 4;
  localparam int TW = 6;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst, flush, flush1;
  logic [NR-1:0]    req_valid, req_ready, req_valid1, req_ready1;
  logic [NR*TW-1:0] req_tag, req_tag1;
  logic [NR*DW-1:0] req_data, req_data1;
  logic [1:0]       cdb_valid;
  logic [2*TW-1:0]  cdb_tag;
  logic [2*DW-1:0]  cdb_data;
  logic [5:0]       cdb_src;
  logic [0:0]       cdb_valid1;
  logic [TW-1:0]    cdb_tag1;
  logic [DW-1:0]    cdb_data1;
  logic [2:0]       cdb_src1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cdb_arbiter #(.NUM_REQ(NR), .NUM_CDB(2), .TAG_W(TW), .DATA_W(DW), .STARVE_LIM(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_tag(req_tag), .req_data(req_data), .req_ready(req_ready),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_src(cdb_src)
  );

  cdb_arbiter #(.NUM_REQ(NR), .NUM_CDB(1), .TAG_W(TW), .DATA_W(DW), .STARVE_LIM(2)) dut1 (
    .clk(clk), .rst(rst), .flush(flush1),
    .req_valid(req_valid1), .req_tag(req_tag1), .req_data(req_data1), .req_ready(req_ready1),
    .cdb_valid(cdb_valid1), .cdb_tag(cdb_tag1), .cdb_data(cdb_data1), .cdb_src(cdb_src1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; flush1 = 1'b0;
    req_valid = '0; req_valid1 = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; flush1 = 1'b0;
    req_valid  = 4'b1111;
    req_tag    = {6'd13, 6'd12, 6'd11, 6'd10};
    req_data   = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
    req_valid1 = '0; req_tag1 = '0; req_data1 = '0;
    for (int c = 0; c < 2; c++) begin
      tick();
      total++;
      if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready cyc%0d got=%b want=0000", c, req_ready); end
      total++;
      if (cdb_valid !== 2'b00 || cdb_tag !== '0 || cdb_data !== '0 || cdb_src !== '0) begin
        bad++; $display("FAIL reset_cdb cyc%0d got v=%b t=%h d=%h s=%h want all zero", c, cdb_valid, cdb_tag, cdb_data, cdb_src);
      end
    end
    rst = 1'b0;
    #1;
    total++;
    if (req_ready !== 4'b0011) begin bad++; $display("FAIL first_grant got=%b want=0011", req_ready); end
    tick();
    total++;
    if (cdb_valid !== 2'b11 || cdb_tag !== {6'd11, 6'd10} || cdb_src !== {3'd1, 3'd0}) begin
      bad++; $display("FAIL first_cdb got v=%b t=%h s=%h want v=11 t=%h s=%h", cdb_valid, cdb_tag, cdb_src, {6'd11, 6'd10}, {3'd1, 3'd0});
    end
  endtask

  // Continues from test_reset: pointer now at 2 with all four FUs still requesting.
  task automatic test_all_valid();
    logic [3:0]    er;
    logic [2*TW-1:0] et;
    logic [2*DW-1:0] ed;
    for (int c = 0; c < 6; c++) begin
      er = (c % 2 == 0) ? 4'b1100 : 4'b0011;
      et = (c % 2 == 0) ? {6'd13, 6'd12} : {6'd11, 6'd10};
      ed = (c % 2 == 0) ? {32'hA000_0003, 32'hA000_0002} : {32'hA000_0001, 32'hA000_0000};
      #1;
      total++;
      if (req_ready !== er) begin bad++; $display("FAIL allv_ready cyc%0d got=%b want=%b", c, req_ready, er); end
      tick();
      total++;
      if (cdb_valid !== 2'b11 || cdb_tag !== et || cdb_data !== ed) begin
        bad++; $display("FAIL allv_cdb cyc%0d got v=%b t=%h d=%h want v=11 t=%h d=%h", c, cdb_valid, cdb_tag, cdb_data, et, ed);
      end
    end
  endtask

  task automatic test_single_wrap();
    do_reset();
    req_valid = 4'b1000;
    req_tag   = {6'h2A, 18'd0};
    req_data  = {32'hDEADBEEF, 96'd0};
    #1;
    total++;
    if (req_ready !== 4'b1000) begin bad++; $display("FAIL single_ready got=%b want=1000", req_ready); end
    tick();
    total++;
    if (cdb_valid !== 2'b01 || cdb_tag !== {6'd0, 6'h2A} || cdb_data !== {32'd0, 32'hDEADBEEF} || cdb_src !== {3'd0, 3'd3}) begin
      bad++; $display("FAIL single_cdb got v=%b t=%h d=%h s=%h want v=01 t=02a d=00000000deadbeef s=03", cdb_valid, cdb_tag, cdb_data, cdb_src);
    end
    req_valid = 4'b1111;
    #1;
    total++;
    if (req_ready !== 4'b0011) begin bad++; $display("FAIL wrap_ready got=%b want=0011", req_ready); end
    req_valid = '0;
    tick();
  endtask

  task automatic test_flush();
    do_reset();
    req_tag   = {6'd13, 6'd12, 6'd11, 6'd10};
    req_valid = 4'b0011;
    tick();
    req_valid = 4'b0101; flush = 1'b1;
    #1;
    total++;
    if (req_ready !== 4'b0000) begin bad++; $display("FAIL flush_ready got=%b want=0000", req_ready); end
    total++;
    if (cdb_valid !== 2'b11 || cdb_tag !== {6'd11, 6'd10}) begin
      bad++; $display("FAIL flush_inflight got v=%b t=%h want v=11 t=%h", cdb_valid, cdb_tag, {6'd11, 6'd10});
    end
    tick();
    total++;
    if (cdb_valid !== 2'b00) begin bad++; $display("FAIL flush_cdb got=%b want=00", cdb_valid); end
    flush = 1'b0;
    #1;
    total++;
    if (req_ready !== 4'b0101) begin bad++; $display("FAIL postflush_ready got=%b want=0101", req_ready); end
    tick();
    total++;
    if (cdb_tag !== {6'd10, 6'd12} || cdb_src !== {3'd0, 3'd2}) begin
      bad++; $display("FAIL postflush_cdb got t=%h s=%h want t=%h s=%h", cdb_tag, cdb_src, {6'd10, 6'd12}, {3'd0, 3'd2});
    end
  endtask

  // Continues from test_flush: last grant was FU0, so the pointer sits at 1.
  task automatic test_idle();
    req_valid = '0;
    #1;
    total++;
    if (req_ready !== 4'b0000) begin bad++; $display("FAIL idle_ready got=%b want=0000", req_ready); end
    tick();
    total++;
    if (cdb_valid !== 2'b00 || cdb_tag !== '0 || cdb_src !== '0) begin
      bad++; $display("FAIL idle_cdb got v=%b t=%h s=%h want zeros", cdb_valid, cdb_tag, cdb_src);
    end
    req_valid = 4'b1111;
    #1;
    total++;
    if (req_ready !== 4'b0110) begin bad++; $display("FAIL idle_hold_ptr got=%b want=0110", req_ready); end
    tick();
    total++;
    if (cdb_src !== {3'd2, 3'd1}) begin bad++; $display("FAIL idle_hold_src got=%h want=%h", cdb_src, {3'd2, 3'd1}); end
    req_valid = '0;
  endtask

  task automatic test_back_to_back();
    logic [3:0] er;
    logic [2:0] es;
    do_reset();
    req_tag1   = {6'd23, 6'd22, 6'd21, 6'd20};
    req_valid1 = 4'b0011;
    for (int c = 0; c < 6; c++) begin
      er = (c % 2 == 0) ? 4'b0001 : 4'b0010;
      es = (c % 2 == 0) ? 3'd0 : 3'd1;
      #1;
      total++;
      if (req_ready1 !== er) begin bad++; $display("FAIL b2b_ready cyc%0d got=%b want=%b", c, req_ready1, er); end
      tick();
      total++;
      if (cdb_valid1 !== 1'b1 || cdb_src1 !== es || cdb_tag1 !== (6'd20 + 6'(es))) begin
        bad++; $display("FAIL b2b_cdb cyc%0d got v=%b s=%0d t=%0d want v=1 s=%0d", c, cdb_valid1, cdb_src1, cdb_tag1, es);
      end
    end
    req_valid1 = '0;
  endtask

`ifdef CDB_AGE_PRIO_EN
  task automatic test_age();
    logic [3:0] vin [5];
    logic [3:0] vexp [5];
    vin  = '{4'b0100, 4'b1100, 4'b0101, 4'b0110, 4'b0110};
    vexp = '{4'b0100, 4'b1000, 4'b0001, 4'b0100, 4'b0010};
    do_reset();
    for (int c = 0; c < 5; c++) begin
      req_valid1 = vin[c];
      #1;
      total++;
      if (req_ready1 !== vexp[c]) begin bad++; $display("FAIL age_ready step%0d got=%b want=%b", c, req_ready1, vexp[c]); end
      tick();
    end
    req_valid1 = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_all_valid();
    test_single_wrap();
    test_flush();
    test_idle();
    test_back_to_back();
`ifdef CDB_AGE_PRIO_EN
    test_age();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
